// File: rtl/mem_fault_unit.sv
// mem_fault_unit: registered data-memory address-exception checker.
// Classifies each M-stage access against the data-RAM range and the device
// windows. It emits a one-cycle exception pulse and holds the first
// unacknowledged fault (cause, bad address, PC) until CP0 accepts it.
// It also keeps a sticky overflow flag and a saturating fault counter.
module mem_fault_unit #(
    parameter logic [31:0]           DM_TOP    = 32'h0000_2FFC,
    parameter int unsigned           DEV_NUM   = 2,
    parameter logic [32*DEV_NUM-1:0] DEV_BASE  = {32'h0000_7F10, 32'h0000_7F00},
    parameter int unsigned           DEV_SPAN  = 12,
    parameter int unsigned           RO_OFFSET = 8,
    parameter int unsigned           CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic             stall_i,
    input  logic [31:0]      addr_i,
    input  logic [3:0]       code_i,
    input  logic [31:0]      pc_i,
    input  logic             ack_i,
    input  logic             cnt_clr_i,
    output logic [1:0]       exc_o,
    output logic             pend_o,
    output logic [1:0]       cause_o,
    output logic [31:0]      badvaddr_o,
    output logic [31:0]      epc_o,
    output logic             ovf_o,
    output logic [CNT_W-1:0] cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       exc_q, exc_d;
    logic [1:0]       cause_q, cause_d;
    logic [31:0]      bad_q, bad_d;
    logic [31:0]      epc_q, epc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             sample;
    logic             is_word, is_half, is_byte, is_store;
    logic             in_ram, in_win, ro_hit;
    logic             fault;
    logic [1:0]       cause_new;
    logic [31:0]      base;

    // Decode the access code and check the address against RAM and device windows
    always_comb begin
        is_word  = 1'b0;
        is_half  = 1'b0;
        is_byte  = 1'b0;
        is_store = 1'b0;
        case (code_i)
            4'd0:    is_word = 1'b1;
            4'd1:    begin is_word = 1'b1; is_store = 1'b1; end
            4'd2:    is_half = 1'b1;
            4'd3:    is_byte = 1'b1;
            4'd4:    is_half = 1'b1;
            4'd5:    is_byte = 1'b1;
            4'd6:    begin is_half = 1'b1; is_store = 1'b1; end
            4'd7:    begin is_byte = 1'b1; is_store = 1'b1; end
            default: ;
        endcase

        sample = valid_i & ~stall_i & (code_i <= 4'd7);

        // 33-bit compares so that bounds near the top of the address space cannot wrap
        in_ram = ({1'b0, addr_i} <= ({1'b0, DM_TOP} + 33'd3));
        in_win = 1'b0;
        ro_hit = 1'b0;
        base   = '0;
        for (int unsigned i = 0; i < DEV_NUM; i++) begin
            base = DEV_BASE[32*i +: 32];
            if ((addr_i >= base) &&
                ({1'b0, addr_i} <= ({1'b0, base} + 33'(DEV_SPAN) - 33'd1)))
                in_win = 1'b1;
            if (addr_i == (base + 32'(RO_OFFSET)))
                ro_hit = 1'b1;
        end

        fault = sample & (~(in_ram | in_win)
                          | (is_word & (addr_i[1:0] != 2'b00))
                          | (is_half & addr_i[0])
                          | ((is_half | is_byte) & in_win)
                          | (is_store & ro_hit));
        cause_new = is_store ? 2'b11 : 2'b10;
    end

    // Next-state logic: capture/overflow FSM, exception pulse and fault counter
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        bad_d   = bad_q;
        epc_d   = epc_q;
        ovf_d   = ovf_q;
        exc_d   = fault ? cause_new : 2'b00;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (fault) begin
                    state_d = HELD;
                    cause_d = cause_new;
                    bad_d   = addr_i;
                    epc_d   = pc_i;
                end
            end
            HELD: begin
                if (fault) begin
                    if (ack_i) begin
                        cause_d = cause_new;
                        bad_d   = addr_i;
                        epc_d   = pc_i;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (ack_i) begin
                    state_d = IDLE;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cnt_clr_i)
            cnt_d = '0;
        else if (fault && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            exc_q   <= '0;
            cause_q <= '0;
            bad_q   <= '0;
            epc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
            cause_q <= cause_d;
            bad_q   <= bad_d;
            epc_q   <= epc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign exc_o      = exc_q;
    assign pend_o     = (state_q == HELD);
    assign cause_o    = cause_q;
    assign badvaddr_o = bad_q;
    assign epc_o      = epc_q;
    assign ovf_o      = ovf_q;
    assign cnt_o      = cnt_q;

endmodule

// File: tb/tb_mem_fault_unit.sv
// tb_mem_fault_unit: directed vector bench for mem_fault_unit.
// Instance A uses the default parameters; instance B has four windows and a 2-bit counter.
module tb_mem_fault_unit;

    localparam logic [3:0] LW = 4'd0, SW = 4'd1, LH = 4'd2, LB = 4'd3;
    localparam logic [3:0] LHU = 4'd4, LBU = 4'd5, SH = 4'd6, SB = 4'd7, NONE = 4'd8;

    typedef struct packed {
        logic        valid;
        logic        stall;
        logic [3:0]  code;
        logic [31:0] addr;
        logic [31:0] pc;
        logic        ack;
        logic        clr;
        logic [1:0]  exc;
        logic        pend;
        logic [1:0]  cause;
        logic [31:0] bad;
        logic [31:0] epc;
        logic        ovf;
        logic [7:0]  cnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic        a_valid = 0, a_stall = 0, a_ack = 0, a_clr = 0;
    logic [3:0]  a_code = NONE;
    logic [31:0] a_addr = '0, a_pc = '0;
    logic [1:0]  a_exc, a_cause;
    logic        a_pend, a_ovf;
    logic [31:0] a_bad, a_epc;
    logic [7:0]  a_cnt;

    logic        b_valid = 0, b_stall = 0, b_ack = 0, b_clr = 0;
    logic [3:0]  b_code = NONE;
    logic [31:0] b_addr = '0, b_pc = '0;
    logic [1:0]  b_exc, b_cause;
    logic        b_pend, b_ovf;
    logic [31:0] b_bad, b_epc;
    logic [1:0]  b_cnt;

    int tests = 0;
    int failed = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mem_fault_unit dut_a (
        .clk(clk), .reset(reset), .valid_i(a_valid), .stall_i(a_stall),
        .addr_i(a_addr), .code_i(a_code), .pc_i(a_pc), .ack_i(a_ack),
        .cnt_clr_i(a_clr), .exc_o(a_exc), .pend_o(a_pend), .cause_o(a_cause),
        .badvaddr_o(a_bad), .epc_o(a_epc), .ovf_o(a_ovf), .cnt_o(a_cnt)
    );

    mem_fault_unit #(
        .DEV_NUM (4),
        .DEV_BASE({32'h0000_7F30, 32'h0000_7F20, 32'h0000_7F10, 32'h0000_7F00}),
        .CNT_W   (2)
    ) dut_b (
        .clk(clk), .reset(reset), .valid_i(b_valid), .stall_i(b_stall),
        .addr_i(b_addr), .code_i(b_code), .pc_i(b_pc), .ack_i(b_ack),
        .cnt_clr_i(b_clr), .exc_o(b_exc), .pend_o(b_pend), .cause_o(b_cause),
        .badvaddr_o(b_bad), .epc_o(b_epc), .ovf_o(b_ovf), .cnt_o(b_cnt)
    );

    function automatic vec_t mk(logic v, logic s, logic [3:0] c, logic [31:0] a,
                                logic [31:0] p, logic ak, logic cl, logic [1:0] e,
                                logic pd, logic [1:0] ca, logic [31:0] bd,
                                logic [31:0] ep, logic ov, logic [7:0] cn);
        vec_t r;
        r.valid = v; r.stall = s; r.code = c; r.addr = a; r.pc = p;
        r.ack = ak; r.clr = cl; r.exc = e; r.pend = pd; r.cause = ca;
        r.bad = bd; r.epc = ep; r.ovf = ov; r.cnt = cn;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_a_all(input string tag, input vec_t v);
        check({tag, " exc"},   32'(a_exc),   32'(v.exc));
        check({tag, " pend"},  32'(a_pend),  32'(v.pend));
        check({tag, " cause"}, 32'(a_cause), 32'(v.cause));
        check({tag, " bad"},   a_bad,        v.bad);
        check({tag, " epc"},   a_epc,        v.epc);
        check({tag, " ovf"},   32'(a_ovf),   32'(v.ovf));
        check({tag, " cnt"},   32'(a_cnt),   32'(v.cnt));
    endtask

    task automatic b_step(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] p, input logic cl, input logic [1:0] e,
                          input logic pd, input logic [31:0] bd, input logic ov,
                          input logic [1:0] cn);
        b_valid = 1'b1; b_code = c; b_addr = a; b_pc = p; b_clr = cl; b_ack = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " exc"},  32'(b_exc),  32'(e));
        check({tag, " pend"}, 32'(b_pend), 32'(pd));
        check({tag, " bad"},  b_bad,       bd);
        check({tag, " ovf"},  32'(b_ovf),  32'(ov));
        check({tag, " cnt"},  32'(b_cnt),  32'(cn));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        //          v s code  addr          pc        ak cl exc pd cau bad           epc       ov cnt
        vecs.push_back(mk(1,0,SW,  32'h2FFC,     32'h100, 0,0, 0,0,0, 32'h0,       32'h0,   0,0));
        vecs.push_back(mk(1,0,SW,  32'h3000,     32'h104, 0,0, 3,1,3, 32'h3000,    32'h104, 0,1));
        vecs.push_back(mk(0,0,NONE,32'h0,        32'h0,   1,0, 0,0,3, 32'h3000,    32'h104, 0,1));
        vecs.push_back(mk(1,0,LH,  32'h1,        32'h108, 0,0, 2,1,2, 32'h1,       32'h108, 0,2));
        vecs.push_back(mk(1,0,LB,  32'h7F04,     32'h10C, 0,0, 2,1,2, 32'h1,       32'h108, 1,3));
        vecs.push_back(mk(0,0,NONE,32'h0,        32'h0,   1,0, 0,0,2, 32'h1,       32'h108, 0,3));
        vecs.push_back(mk(1,0,SW,  32'h7F18,     32'h110, 0,0, 3,1,3, 32'h7F18,    32'h110, 0,4));
        vecs.push_back(mk(1,0,LW,  32'h7F18,     32'h114, 1,0, 0,0,3, 32'h7F18,    32'h110, 0,4));
        vecs.push_back(mk(1,0,SW,  32'h7F14,     32'h118, 0,0, 0,0,3, 32'h7F18,    32'h110, 0,4));
        vecs.push_back(mk(1,0,SW,  32'h7F1C,     32'h11C, 0,0, 3,1,3, 32'h7F1C,    32'h11C, 0,5));
        vecs.push_back(mk(1,0,LW,  32'h7F00,     32'h11E, 0,0, 0,1,3, 32'h7F1C,    32'h11C, 0,5));
        vecs.push_back(mk(1,0,LW,  32'h2,        32'h120, 1,0, 2,1,2, 32'h2,       32'h120, 0,6));
        vecs.push_back(mk(0,0,NONE,32'h0,        32'h0,   1,0, 0,0,2, 32'h2,       32'h120, 0,6));
        vecs.push_back(mk(1,0,LBU, 32'h2FFF,     32'h124, 0,0, 0,0,2, 32'h2,       32'h120, 0,6));
        vecs.push_back(mk(1,0,NONE,32'h3000,     32'h124, 0,0, 0,0,2, 32'h2,       32'h120, 0,6));
        vecs.push_back(mk(1,0,4'hF,32'h3001,     32'h124, 0,0, 0,0,2, 32'h2,       32'h120, 0,6));
        vecs.push_back(mk(1,1,LW,  32'h3,        32'h128, 0,0, 0,0,2, 32'h2,       32'h120, 0,6));
        vecs.push_back(mk(1,1,LW,  32'h3,        32'h128, 0,0, 0,0,2, 32'h2,       32'h120, 0,6));
        vecs.push_back(mk(1,1,LW,  32'h3,        32'h128, 0,0, 0,0,2, 32'h2,       32'h120, 0,6));
        vecs.push_back(mk(1,0,LW,  32'h3,        32'h128, 0,0, 2,1,2, 32'h3,       32'h128, 0,7));
        vecs.push_back(mk(1,0,SB,  32'h7F10,     32'h12C, 0,0, 3,1,2, 32'h3,       32'h128, 1,8));
        vecs.push_back(mk(1,0,SH,  32'h7F11,     32'h130, 1,0, 3,1,3, 32'h7F11,    32'h130, 1,9));
        vecs.push_back(mk(1,0,LH,  32'h5,        32'h134, 0,1, 2,1,3, 32'h7F11,    32'h130, 1,0));
        vecs.push_back(mk(0,0,NONE,32'h0,        32'h0,   1,0, 0,0,3, 32'h7F11,    32'h130, 0,0));
        vecs.push_back(mk(0,0,NONE,32'h0,        32'h0,   1,0, 0,0,3, 32'h7F11,    32'h130, 0,0));
        vecs.push_back(mk(1,0,LHU, 32'hFFFFFFFE, 32'h138, 0,0, 2,1,2, 32'hFFFFFFFE,32'h138, 0,1));
        vecs.push_back(mk(1,0,LW,  32'h7F0C,     32'h13C, 0,0, 2,1,2, 32'hFFFFFFFE,32'h138, 1,2));
        vecs.push_back(mk(1,0,LW,  32'h4,        32'h140, 0,0, 0,1,2, 32'hFFFFFFFE,32'h138, 1,2));
        vecs.push_back(mk(0,0,SW,  32'h3000,     32'h144, 0,0, 0,1,2, 32'hFFFFFFFE,32'h138, 1,2));

        // Reset held from time 0: everything must read zero before any edge
        #2;
        check("rst0 exc",  32'(a_exc),  32'd0);
        check("rst0 pend", 32'(a_pend), 32'd0);
        check("rst0 cnt",  32'(a_cnt),  32'd0);
        check("rst0 bad",  a_bad,       32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            a_valid = vecs[i].valid; a_stall = vecs[i].stall; a_code = vecs[i].code;
            a_addr  = vecs[i].addr;  a_pc    = vecs[i].pc;    a_ack  = vecs[i].ack;
            a_clr   = vecs[i].clr;
            @(posedge clk);
            #1;
            check_a_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset between edges while pend=1, ovf=1, cnt=2
        a_valid = 1'b0; a_code = NONE; a_ack = 1'b0; a_clr = 1'b0; a_stall = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_a_all("async_rst", mk(0,0,NONE,0,0,0,0, 0,0,0,32'h0,32'h0,0,0));
        @(negedge clk);
        reset = 1'b1;

        // First sample after release is taken on the next edge
        a_valid = 1'b1; a_code = SW; a_addr = 32'h3000; a_pc = 32'h200;
        @(posedge clk);
        #1;
        check_a_all("post_rst", mk(1,0,SW,32'h3000,32'h200,0,0, 3,1,3,32'h3000,32'h200,0,1));
        a_valid = 1'b0; a_code = NONE;

        // Four-window instance with a 2-bit saturating counter
        b_step("b1 lw win2", LW, 32'h7F24, 32'h300, 0, 2'b00, 0, 32'h0,    0, 2'd0);
        b_step("b2 sh win3", SH, 32'h7F30, 32'h304, 0, 2'b11, 1, 32'h7F30, 0, 2'd1);
        b_step("b3 sh win3", SH, 32'h7F32, 32'h308, 0, 2'b11, 1, 32'h7F30, 1, 2'd2);
        b_step("b4 lw win3", LW, 32'h7F34, 32'h30C, 0, 2'b00, 1, 32'h7F30, 1, 2'd2);
        b_step("b5 sb ro",   SB, 32'h7F38, 32'h310, 0, 2'b11, 1, 32'h7F30, 1, 2'd3);
        b_step("b6 sat",     LB, 32'h7F3C, 32'h314, 0, 2'b10, 1, 32'h7F30, 1, 2'd3);
        b_step("b7 sat",     LW, 32'h7F3C, 32'h318, 0, 2'b10, 1, 32'h7F30, 1, 2'd3);
        b_step("b8 clr",     SB, 32'h7F38, 32'h31C, 1, 2'b11, 1, 32'h7F30, 1, 2'd0);
        b_step("b9 cnt",     LW, 32'h7F3C, 32'h320, 0, 2'b10, 1, 32'h7F30, 1, 2'd1);
        b_valid = 1'b0; b_code = NONE;

        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
